// File: rtl/time_pkg.sv
// Shared widths, limits, request indices and BCD increment helpers for the
// HH:MM:SS time keeper.
package time_pkg;

  localparam int HRS_D_W = 2;
  localparam int DIG_W   = 4;
  localparam int TENS_W  = 3;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HRS_MAX = 23;

  localparam int REQ_TICK = 0;
  localparam int REQ_SEC  = 1;
  localparam int REQ_MIN  = 2;
  localparam int REQ_HRS  = 3;
  localparam int NUM_REQ  = 4;

  typedef struct packed {
    logic [TENS_W-1:0] tens;
    logic [DIG_W-1:0]  units;
    logic              wrap;
  } bcd60_t;

  typedef struct packed {
    logic [HRS_D_W-1:0] tens;
    logic [DIG_W-1:0]   units;
  } bcd24_t;

  // Two-digit BCD increment in 00..max_val; wrap flags the roll back to 00.
  function automatic bcd60_t inc_base60(input logic [TENS_W-1:0] tens,
                                        input logic [DIG_W-1:0]  units,
                                        input int                max_val);
    bcd60_t r;
    r.tens  = tens;
    r.units = units + DIG_W'(1);
    r.wrap  = 1'b0;
    if (tens == TENS_W'(max_val / 10) && units == DIG_W'(max_val % 10)) begin
      r.tens  = '0;
      r.units = '0;
      r.wrap  = 1'b1;
    end else if (units == DIG_W'(9)) begin
      r.tens  = tens + TENS_W'(1);
      r.units = '0;
    end
    return r;
  endfunction

  function automatic bcd24_t inc_hours(input bcd24_t h);
    bcd24_t r;
    if (h.tens == HRS_D_W'(HRS_MAX / 10) && h.units == DIG_W'(HRS_MAX % 10)) begin
      r = '0;
    end else if (h.units == DIG_W'(9)) begin
      r.tens  = h.tens + HRS_D_W'(1);
      r.units = '0;
    end else begin
      r.tens  = h.tens;
      r.units = h.units + DIG_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/time_req_arbiter.sv
// Pending-request register (a new request wins over the clear of its own flag)
// and fixed-priority one-hot grant, lowest index first.
module time_req_arbiter
  import time_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] pending_o,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] pending_d;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] taken;

  // taken[gi] is set when any lower-index (higher-priority) flag is pending.
  assign taken[0] = 1'b0;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_prio
    assign grant[gi] = pending_q[gi] & ~taken[gi];
    if (gi < NUM_REQ - 1) begin : g_chain
      assign taken[gi+1] = taken[gi] | pending_q[gi];
    end
  end

  assign pending_d = (pending_q & ~grant) | req_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign grant_o   = grant;

endmodule

// File: rtl/time_keeper_ctrl.sv
// Owns the HH:MM:SS BCD time registers: one-second prescaler, request
// arbitration and a single BCD update per clock.
module time_keeper_ctrl
  import time_pkg::*;
#(
  parameter int CLK_HZ = 31_500_000,
  parameter int CNT_W  = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run_en,
  input  logic       adj_sec,
  input  logic       adj_min,
  input  logic       adj_hrs,
  output logic [1:0] hrs_d,
  output logic [3:0] hrs_u,
  output logic [2:0] min_d,
  output logic [3:0] min_u,
  output logic [2:0] sec_d,
  output logic [3:0] sec_u,
  output logic [3:0] color_offset,
  output logic [3:0] pending,
  output logic       sec_strobe
);

  logic [CNT_W-1:0]   cnt_q;
  logic               wrap_tick;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;

  logic [HRS_D_W-1:0] hrs_d_q, hrs_d_d;
  logic [DIG_W-1:0]   hrs_u_q, hrs_u_d;
  logic [TENS_W-1:0]  min_d_q, min_d_d;
  logic [DIG_W-1:0]   min_u_q, min_u_d;
  logic [TENS_W-1:0]  sec_d_q, sec_d_d;
  logic [DIG_W-1:0]   sec_u_q, sec_u_d;
  logic [3:0]         color_q, color_d;
  logic               sec_strobe_q;

  bcd60_t sec_inc;
  bcd60_t min_inc;
  bcd24_t hrs_inc;

  assign wrap_tick = run_en && (cnt_q == CNT_W'(CLK_HZ - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (run_en) begin
      cnt_q <= wrap_tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign req[REQ_TICK] = wrap_tick;
  assign req[REQ_SEC]  = adj_sec;
  assign req[REQ_MIN]  = adj_min;
  assign req[REQ_HRS]  = adj_hrs;

  time_req_arbiter u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req),
    .pending_o (pending),
    .grant_o   (grant)
  );

  always_comb begin
    sec_inc = inc_base60(sec_d_q, sec_u_q, SEC_MAX);
    min_inc = inc_base60(min_d_q, min_u_q, MIN_MAX);
    hrs_inc = inc_hours({hrs_d_q, hrs_u_q});

    hrs_d_d = hrs_d_q;
    hrs_u_d = hrs_u_q;
    min_d_d = min_d_q;
    min_u_d = min_u_q;
    sec_d_d = sec_d_q;
    sec_u_d = sec_u_q;
    color_d = color_q;

    // Grant is one-hot, so at most one of these branches fires per edge.
    if (grant[REQ_TICK]) begin
      sec_d_d = sec_inc.tens;
      sec_u_d = sec_inc.units;
      if (sec_inc.wrap) begin
        min_d_d = min_inc.tens;
        min_u_d = min_inc.units;
        color_d = color_q + 4'd1;
        if (min_inc.wrap) begin
          hrs_d_d = hrs_inc.tens;
          hrs_u_d = hrs_inc.units;
        end
      end
    end else if (grant[REQ_SEC]) begin
      sec_d_d = sec_inc.tens;
      sec_u_d = sec_inc.units;
    end else if (grant[REQ_MIN]) begin
      min_d_d = min_inc.tens;
      min_u_d = min_inc.units;
      color_d = color_q + 4'd1;
    end else if (grant[REQ_HRS]) begin
      hrs_d_d = hrs_inc.tens;
      hrs_u_d = hrs_inc.units;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hrs_d_q      <= '0;
      hrs_u_q      <= '0;
      min_d_q      <= '0;
      min_u_q      <= '0;
      sec_d_q      <= '0;
      sec_u_q      <= '0;
      color_q      <= '0;
      sec_strobe_q <= 1'b0;
    end else begin
      hrs_d_q      <= hrs_d_d;
      hrs_u_q      <= hrs_u_d;
      min_d_q      <= min_d_d;
      min_u_q      <= min_u_d;
      sec_d_q      <= sec_d_d;
      sec_u_q      <= sec_u_d;
      color_q      <= color_d;
      sec_strobe_q <= grant[REQ_TICK];
    end
  end

  assign hrs_d        = hrs_d_q;
  assign hrs_u        = hrs_u_q;
  assign min_d        = min_d_q;
  assign min_u        = min_u_q;
  assign sec_d        = sec_d_q;
  assign sec_u        = sec_u_q;
  assign color_offset = color_q;
  assign sec_strobe   = sec_strobe_q;

endmodule

// File: tb/tb_time_keeper_ctrl.sv
// Directed bench for time_keeper_ctrl with a 4-cycle second.
module tb_time_keeper_ctrl;

  localparam int CLK_HZ = 4;
  localparam int CNT_W  = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run_en = 1'b0;
  logic       adj_sec = 1'b0;
  logic       adj_min = 1'b0;
  logic       adj_hrs = 1'b0;
  logic [1:0] hrs_d;
  logic [3:0] hrs_u;
  logic [2:0] min_d;
  logic [3:0] min_u;
  logic [2:0] sec_d;
  logic [3:0] sec_u;
  logic [3:0] color_offset;
  logic [3:0] pending;
  logic       sec_strobe;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       s;
    logic       m;
    logic       h;
    int         exp_time;
    logic [3:0] exp_pend;
    logic [3:0] exp_color;
    logic       exp_strobe;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  time_keeper_ctrl #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run_en       (run_en),
    .adj_sec      (adj_sec),
    .adj_min      (adj_min),
    .adj_hrs      (adj_hrs),
    .hrs_d        (hrs_d),
    .hrs_u        (hrs_u),
    .min_d        (min_d),
    .min_u        (min_u),
    .sec_d        (sec_d),
    .sec_u        (sec_u),
    .color_offset (color_offset),
    .pending      (pending),
    .sec_strobe   (sec_strobe)
  );

  // Time as a decimal HHMMSS number; X/Z digits propagate into the result.
  function automatic logic [31:0] cur_time();
    logic [31:0] h, m, s;
    h = 32'(hrs_d) * 32'd10 + 32'(hrs_u);
    m = 32'(min_d) * 32'd10 + 32'(min_u);
    s = 32'(sec_d) * 32'd10 + 32'(sec_u);
    return h * 32'd10000 + m * 32'd100 + s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int t, input logic [3:0] p,
                         input logic [3:0] c, input logic st);
    chk($sformatf("%s time", tag), cur_time(), 32'(t));
    chk($sformatf("%s pending", tag), 32'(pending), 32'(p));
    chk($sformatf("%s color", tag), 32'(color_offset), 32'(c));
    chk($sformatf("%s strobe", tag), 32'(sec_strobe), 32'(st));
  endtask

  // One clock: requests are high across exactly one rising edge; returns on the falling edge.
  task automatic drive(input logic s, input logic m, input logic h);
    adj_sec = s;
    adj_min = m;
    adj_hrs = h;
    @(posedge clk);
    #1;
    adj_sec = 1'b0;
    adj_min = 1'b0;
    adj_hrs = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // which: 1=sec 2=min 3=hrs; each request is given one extra cycle to be serviced.
  task automatic adj(input int which, input int n);
    repeat (n) begin
      drive(which == 1, which == 2, which == 3);
      idle(1);
    end
  endtask

  task automatic do_reset(input logic run);
    @(negedge clk);
    reset_n = 1'b0;
    adj_sec = 1'b0;
    adj_min = 1'b0;
    adj_hrs = 1'b0;
    run_en  = run;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Adjust-only vectors with the prescaler frozen at 0.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 0,     4'b0000, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 0,     4'b0010, 4'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1,     4'b0000, 4'd0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1,     4'b1110, 4'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 2,     4'b1100, 4'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 102,   4'b1000, 4'd1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 10102, 4'b0000, 4'd1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 10102, 4'b0100, 4'd1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 10202, 4'b0100, 4'd2, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 10302, 4'b0000, 4'd3, 1'b0};

    do_reset(1'b0);
    chk_all("reset", 0, 4'b0000, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].s, tbl[i].m, tbl[i].h);
      $display("vec %0d: req s/m/h=%b%b%b time=%0d pending=%b color=%0d",
               i, tbl[i].s, tbl[i].m, tbl[i].h, cur_time(), pending, color_offset);
      chk_all($sformatf("vec%0d", i), tbl[i].exp_time, tbl[i].exp_pend,
              tbl[i].exp_color, tbl[i].exp_strobe);
    end

    // Preload through adjusts, field wraps without carry, then full 24 h wrap by tick.
    do_reset(1'b0);
    adj(3, 23);
    chk("preload hrs", cur_time(), 230000);
    adj(3, 1);
    chk("adj hrs 23->00", cur_time(), 0);
    adj(3, 23);
    adj(2, 59);
    chk("preload min", cur_time(), 235900);
    chk("preload color", 32'(color_offset), 32'd11);
    adj(1, 59);
    chk("preload sec", cur_time(), 235959);
    adj(1, 1);
    chk("adj sec no carry", cur_time(), 235900);
    chk("adj sec color", 32'(color_offset), 32'd11);
    adj(1, 59);
    adj(2, 1);
    chk("adj min no carry", cur_time(), 230059);
    chk("adj min color", 32'(color_offset), 32'd12);
    adj(2, 59);
    chk("wrap start", cur_time(), 235959);
    run_en = 1'b1;
    idle(4);
    chk("wrap tick pending", 32'(pending), 32'b0001);
    chk("wrap before service", cur_time(), 235959);
    run_en = 1'b0;
    idle(1);
    chk_all("full wrap", 0, 4'b0000, 4'd8, 1'b1);
    idle(8);
    chk_all("frozen", 0, 4'b0000, 4'd8, 1'b0);

    // Tick timing, tick/adjust collision and coalescing behind a pending tick.
    do_reset(1'b1);
    idle(4);
    chk_all("first wrap", 0, 4'b0001, 4'd0, 1'b0);
    idle(1);
    chk_all("first tick", 1, 4'b0000, 4'd0, 1'b1);
    idle(1);
    chk("strobe low", 32'(sec_strobe), 32'd0);
    idle(33);
    chk_all("nine ticks", 9, 4'b0000, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk_all("collide set", 9, 4'b0011, 4'd0, 1'b0);
    idle(1);
    chk_all("collide tick", 10, 4'b0010, 4'd0, 1'b1);
    idle(1);
    chk_all("collide sec", 11, 4'b0000, 4'd0, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 1'b0);
    chk_all("coalesce set", 11, 4'b0101, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk_all("coalesce tick", 12, 4'b0100, 4'd0, 1'b1);
    idle(1);
    chk_all("coalesce min", 112, 4'b0000, 4'd1, 1'b0);
    idle(2);
    chk("coalesce once", cur_time(), 112);

    // Asynchronous reset with a request still pending.
    run_en = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    chk("pre-reset pending", 32'(pending), 32'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async reset", 0, 4'b0000, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    chk_all("after release", 0, 4'b0000, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/time_keeper_ctrl.md
Name: time_keeper_ctrl

Overview:
- Controller that owns the HH:MM:SS BCD time registers for the VGA clock display.
- Generates the one-second tick from a clk prescaler and arbitrates among four update requesters: tick, adj_sec, adj_min, adj_hrs.
- Applies at most one update per clock, with BCD carry and 24 h wrap.
- Feeds digit values and color_offset to the character renderer; button_pulse outputs drive the adj_* inputs.

Parameters:
- CLK_HZ, 31_500_000, pixel-clock cycles per second; prescaler terminal count is CLK_HZ-1.
- CNT_W, 26, prescaler width; must satisfy 2^CNT_W >= CLK_HZ.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- run_en  in  1  1 = prescaler counts; 0 = prescaler holds its value (adjust requests still serviced)
- adj_sec  in  1  single-cycle adjust-seconds request
- adj_min  in  1  single-cycle adjust-minutes request
- adj_hrs  in  1  single-cycle adjust-hours request
- hrs_d  out  2  hours tens, 0..2
- hrs_u  out  4  hours units, 0..9 (0..3 when hrs_d==2)
- min_d  out  3  minutes tens, 0..5
- min_u  out  4  minutes units, 0..9
- sec_d  out  3  seconds tens, 0..5
- sec_u  out  4  seconds units, 0..9
- color_offset  out  4  increments on every minutes change, wraps 15->0
- pending  out  4  {hrs,min,sec,tick} pending request flags
- sec_strobe  out  1  one-cycle pulse on the edge a tick update is applied

Behaviour:
- Reset (reset_n low, asynchronous): all digits 0, color_offset 0, pending 0, prescaler 0, sec_strobe 0. State stays held while reset_n is low.
- Prescaler:
  - When run_en=1: counts 0..CLK_HZ-1, wraps to 0.
  - The edge that wraps sets pending[0].
- Request capture: adj_x high before edge k sets pending[x] at edge k.
- Coalescing: a request arriving while its flag is already set is coalesced and not counted.
- Service at each edge:
  - Select the highest-priority flag pending before the edge. Priority: tick(0) > sec(1) > min(2) > hrs(3).
  - Clear that flag and apply its update on the same edge. Update latency is one cycle after the flag is set.
- Set/clear collision: if a new request for the serviced source arrives on the same edge, set wins and the flag remains 1.
- Tick update: full carry chain in one cycle.
  - sec_u+1; 9 -> 0 carries into sec_d.
  - sec_d 5 -> 0 carries into min_u.
  - min_u 9 -> 0 carries into min_d.
  - min_d 5 -> 0 carries into hrs.
  - Hours: 23 -> 00; otherwise hrs_u 9 -> 0 with hrs_d+1.
  - sec_strobe=1 for that cycle.
- adj_sec update: seconds field +1 within 00..59; 59 -> 00 with no carry into minutes.
- adj_min update: minutes field +1 within 00..59; 59 -> 00 with no carry into hours.
- adj_hrs update: hours field +1 within 00..23; 23 -> 00.
- color_offset: +1 on any update that changes min_u or min_d, whether from tick carry or adj_min. Exactly one increment per update.
- Unserviced requests wait in pending; no request is ever dropped except by coalescing.
- Illegal digit values are never produced; all width arithmetic wraps within the field range listed above.
- run_en deassert mid-count: prescaler freezes; an already-pending tick is still serviced.
- Reset mid-operation: pending flags are discarded; no update is applied after release until new requests arrive.

Decomposition:
- Shared package (time_pkg):
  - digit width constants: HRS_D_W=2, DIG_W=4, TENS_W=3
  - limits: SEC_MAX=59, MIN_MAX=59, HRS_MAX=23
  - request index constants: REQ_TICK=0, REQ_SEC=1, REQ_MIN=2, REQ_HRS=3
  - NUM_REQ=4
- Sub-module time_req_arbiter: holds the pending register (set-wins-over-clear) and the fixed-priority one-hot grant. The top level holds the prescaler and BCD update logic.

Test Plan:
- Reset + tick, CLK_HZ=4, run_en=1: 00:00:00 after reset -> sec_u=1 and sec_strobe pulse 5 cycles after reset release (4 count + 1 service); 10 ticks -> 00:00:10.
- Full wrap, preload via adjusts to 23:59:59 then one tick -> 00:00:00, color_offset +1, pending==0 afterwards.
- Simultaneous requests, adj_sec+adj_min+adj_hrs in one cycle at 12:30:45 -> pending=4'b1110, then services over 3 consecutive edges (sec, min, hrs) -> 13:31:46, color_offset +1.
- Tick/adjust collision, tick wraps on the same edge adj_sec asserts at 00:00:09 -> tick serviced first (00:00:10), adj_sec next edge (00:00:11).
- Adjust no-carry, adj_sec at 10:20:59 -> 10:20:00; adj_min at 10:59:00 -> 10:00:00 with color_offset +1; adj_hrs at 23:xx -> 00:xx.
- Coalesce/reset, adj_min pulsed twice while pending[2] set behind a pending tick -> one minute increment only; assert reset_n low with pending!=0 -> all outputs 0 immediately (asynchronous) and no update after release.
